// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: one registered one-hot grant plus binary select for the bus switch.
// Optional hold-time preemption is built when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
    parameter int SIZE     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SIZE-1:0]             req,
    output logic [SIZE-1:0]             grant,
    output logic [$clog2(SIZE)-1:0]     sel,
    output logic                        bus_valid,
    output logic                        preempt
);

    localparam int SEL_WIDTH = $clog2(SIZE);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_r;
    logic [SEL_WIDTH-1:0] last_r;
    logic [SEL_WIDTH-1:0] pick_s;
    logic                 owner_req_s;
    logic                 others_s;
    logic                 any_req_s;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int                 CNT_W    = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0]   HOLD_MAX = CNT_W'(MAX_HOLD - 1);
    logic [CNT_W-1:0]              hold_cnt_r;
`endif

    // First set request bit at or after start, wrapping; SIZE is a power of two so index math wraps naturally.
    function automatic logic [SEL_WIDTH-1:0] rr_pick(input logic [SIZE-1:0] r,
                                                      input logic [SEL_WIDTH-1:0] start);
        logic                 found;
        logic [SEL_WIDTH-1:0] idx;
        logic [SEL_WIDTH-1:0] pick;
        found = 1'b0;
        pick  = start;
        for (int i = 0; i < SIZE; i++) begin
            idx = start + i[SEL_WIDTH-1:0];
            if (!found && r[idx]) begin
                found = 1'b1;
                pick  = idx;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [SIZE-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
        return {{(SIZE-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Arbitration inputs; last_r always equals the current owner while BUSY.
    always_comb begin
        pick_s      = rr_pick(req, last_r + {{(SEL_WIDTH-1){1'b0}}, 1'b1});
        owner_req_s = |(req & grant);
        others_s    = |(req & ~grant);
        any_req_s   = |req;
    end

    // Arbiter state machine with registered grant, select, valid and preempt outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            grant     <= {SIZE{1'b0}};
            sel       <= {SEL_WIDTH{1'b0}};
            bus_valid <= 1'b0;
            preempt   <= 1'b0;
            last_r    <= {SEL_WIDTH{1'b1}};
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt_r <= {CNT_W{1'b0}};
`endif
        end else begin
            preempt <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        state_r   <= BUSY;
                        grant     <= onehot(pick_s);
                        sel       <= pick_s;
                        bus_valid <= 1'b1;
                        last_r    <= pick_s;
`ifdef BUS_ARB_TIMEOUT_EN
                        hold_cnt_r <= {CNT_W{1'b0}};
`endif
                    end else begin
                        grant     <= {SIZE{1'b0}};
                        bus_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (owner_req_s) begin
`ifdef BUS_ARB_TIMEOUT_EN
                        if ((hold_cnt_r == HOLD_MAX) && others_s) begin
                            grant      <= onehot(pick_s);
                            sel        <= pick_s;
                            last_r     <= pick_s;
                            hold_cnt_r <= {CNT_W{1'b0}};
                            preempt    <= 1'b1;
                        end else if (hold_cnt_r != HOLD_MAX) begin
                            hold_cnt_r <= hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            hold_cnt_r <= hold_cnt_r;
                        end
`else
                        grant <= grant;
`endif
                    end else if (others_s) begin
                        // Hand over on the same edge so the bus never sees an idle bubble.
                        grant  <= onehot(pick_s);
                        sel    <= pick_s;
                        last_r <= pick_s;
`ifdef BUS_ARB_TIMEOUT_EN
                        hold_cnt_r <= {CNT_W{1'b0}};
`endif
                    end else begin
                        state_r   <= IDLE;
                        grant     <= {SIZE{1'b0}};
                        bus_valid <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    grant     <= {SIZE{1'b0}};
                    bus_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized requests against a behavioural model.
module tb_bus_arbiter;

    localparam int SIZE     = 4;
    localparam int MAX_HOLD = 8;

    logic            clk;
    logic            reset;
    logic [SIZE-1:0] req;
    logic [SIZE-1:0] grant;
    logic [1:0]      sel;
    logic            bus_valid;
    logic            preempt;

    int tests = 0;
    int fails = 0;

    // Reference model state: owner index (-1 when idle), last granted index, hold count.
    int owner    = -1;
    int last     = SIZE - 1;
    int hold     = 0;
    int exp_sel  = 0;
    int exp_pre  = 0;

    bus_arbiter #(.SIZE(SIZE), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .sel       (sel),
        .bus_valid (bus_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find_from(input int start, input logic [SIZE-1:0] r);
        for (int k = 0; k < SIZE; k++) begin
            if (r[(start + k) % SIZE]) return (start + k) % SIZE;
        end
        return -1;
    endfunction

    task automatic model_update(input logic [SIZE-1:0] r, input logic rs);
        int w;
        if (!rs) begin
            owner = -1; last = SIZE - 1; hold = 0; exp_sel = 0; exp_pre = 0;
        end else begin
            exp_pre = 0;
            if (owner < 0) begin
                w = find_from(last + 1, r);
                if (w >= 0) begin
                    owner = w; last = w; exp_sel = w; hold = 0;
                end
            end else if (r[owner]) begin
`ifdef BUS_ARB_TIMEOUT_EN
                if (hold == MAX_HOLD - 1 && (r & ~(4'b0001 << owner)) != 4'b0000) begin
                    w = find_from(owner + 1, r);
                    owner = w; last = w; exp_sel = w; hold = 0; exp_pre = 1;
                end else if (hold < MAX_HOLD - 1) begin
                    hold = hold + 1;
                end
`endif
            end else begin
                w = find_from(owner + 1, r);
                if (w >= 0) begin
                    owner = w; last = w; exp_sel = w; hold = 0;
                end else begin
                    owner = -1;
                end
            end
        end
    endtask

    task automatic step(input logic [SIZE-1:0] r, input logic rs);
        logic [SIZE-1:0] eg;
        req   = r;
        reset = rs;
        @(posedge clk);
        model_update(r, rs);
        #1;
        eg = (owner < 0) ? 4'b0000 : (4'b0001 << owner);
        check_eq("grant", 32'(grant), 32'(eg));
        check_eq("sel", 32'(sel), 32'(exp_sel));
        check_eq("bus_valid", 32'(bus_valid), (owner >= 0) ? 32'd1 : 32'd0);
        check_eq("preempt", 32'(preempt), 32'(exp_pre));
    endtask

    initial begin
        logic [SIZE-1:0] cur;
        logic [SIZE-1:0] rq;
        reset = 1'b0;
        req   = 4'b0000;

        // Reset held with all requests pending.
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        check_eq("t1_grant", 32'(grant), 32'd0);
        check_eq("t1_valid", 32'(bus_valid), 32'd0);

        // Single request, then release keeps sel.
        step(4'b0100, 1'b1);
        check_eq("t2_grant", 32'(grant), 32'h4);
        check_eq("t2_sel", 32'(sel), 32'd2);
        step(4'b0000, 1'b1);
        check_eq("t2_idle_grant", 32'(grant), 32'd0);
        check_eq("t2_idle_sel", 32'(sel), 32'd2);

        // Rotation with every owner dropping after one granted cycle.
        step(4'b0000, 1'b0);
        rq = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step(rq, 1'b1);
            check_eq("t3_sel", 32'(sel), 32'(k % 4));
            check_eq("t3_valid", 32'(bus_valid), 32'd1);
            rq = 4'b1111 & ~grant;
        end

        // Owner 1 hands over directly to 3.
        step(4'b0000, 1'b0);
        step(4'b0010, 1'b1);
        step(4'b1010, 1'b1);
        check_eq("t4_hold", 32'(grant), 32'h2);
        step(4'b1000, 1'b1);
        check_eq("t4_grant", 32'(grant), 32'h8);
        check_eq("t4_sel", 32'(sel), 32'd3);

        // Constant contention: preempted only with the timeout feature.
        step(4'b0000, 1'b0);
        for (int c = 0; c <= MAX_HOLD; c++) begin
            step(4'b0011, 1'b1);
`ifdef BUS_ARB_TIMEOUT_EN
            check_eq("t5_grant", 32'(grant), (c < MAX_HOLD) ? 32'h1 : 32'h2);
            check_eq("t5_pre", 32'(preempt), (c < MAX_HOLD) ? 32'd0 : 32'd1);
`else
            check_eq("t5_grant", 32'(grant), 32'h1);
`endif
        end
        step(4'b0000, 1'b0);
        for (int c = 0; c < 2 * MAX_HOLD + 2; c++) begin
            step(4'b0001, 1'b1);
            check_eq("t5_alone", 32'(grant), 32'h1);
        end

        // Reset mid-grant, arbitration restarts from index 0.
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b1);
        check_eq("t6_pre_grant", 32'(grant), 32'h4);
        step(4'b0100, 1'b0);
        check_eq("t6_rst_grant", 32'(grant), 32'd0);
        check_eq("t6_rst_sel", 32'(sel), 32'd0);
        step(4'b1111, 1'b1);
        check_eq("t6_restart", 32'(grant), 32'h1);

        // Randomized requests with persistence and occasional reset.
        cur = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            cur = cur ^ 4'($urandom() & $urandom());
            step(cur, ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
